// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit -- RV32I byte/half/word load-store unit with a latency-N
// synchronous data memory port. Optional macro LSU_MISALIGN_TRAP_EN.
// Rev 1.0
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [31:0]           base,
    input  logic [31:0]           offset,
    input  logic [31:0]           store_data,
    output logic                  resp_valid,
    output logic [31:0]           load_data,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_byteena,
    output logic [31:0]           mem_data,
    output logic                  mem_wren,
    input  logic [31:0]           mem_q
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_t                  state_q;
    logic [1:0]              cnt_q;
    logic [2:0]              funct3_q;
    logic [1:0]              off_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic                    err_q;
    logic [31:0]             load_data_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [3:0]              mem_byteena_q;
    logic [31:0]             mem_data_q;
    logic                    mem_wren_q;

    logic [31:0] w_eff;
    logic        w_unused_eff;
    logic        w_legal;
    logic        w_misalign;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rdata;

    assign w_eff        = base + offset;
    assign w_unused_eff = ^w_eff;

    always_comb begin
        w_legal    = 1'b0;
        w_misalign = 1'b0;
        w_off      = w_eff[1:0];
        w_be       = 4'b1111;
        w_wdata    = store_data;

        if (is_store)
            w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);

`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = ((funct3[1:0] == 2'b01) && w_eff[0]) ||
                     ((funct3[1:0] == 2'b10) && (w_eff[1:0] != 2'b00));
`else
        // Without the trap, halves and words silently snap to natural alignment.
        if (funct3[1:0] == 2'b01)
            w_off = {w_eff[1], 1'b0};
        else if (funct3[1:0] == 2'b10)
            w_off = 2'b00;
`endif

        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    w_byte = mem_q[7:0];
            2'd1:    w_byte = mem_q[15:8];
            2'd2:    w_byte = mem_q[23:16];
            default: w_byte = mem_q[31:24];
        endcase
        w_half = off_q[1] ? mem_q[31:16] : mem_q[15:0];

        case (funct3_q)
            3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
            3'b100:  w_rdata = {24'd0, w_byte};
            3'b101:  w_rdata = {16'd0, w_half};
            default: w_rdata = mem_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            funct3_q      <= 3'd0;
            off_q         <= 2'd0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            err_q         <= 1'b0;
            load_data_q   <= 32'd0;
            mem_addr_q    <= '0;
            mem_byteena_q <= 4'd0;
            mem_data_q    <= 32'd0;
            mem_wren_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        funct3_q    <= funct3;
                        off_q       <= w_off;
                        req_ready_q <= 1'b0;
                        if (!w_legal || w_misalign) begin
                            state_q      <= ERR;
                            resp_valid_q <= 1'b1;
                            err_q        <= 1'b1;
                            load_data_q  <= 32'd0;
                        end else begin
                            mem_addr_q    <= w_eff[ADDR_WIDTH+1:2];
                            mem_byteena_q <= w_be;
                            if (is_store) begin
                                state_q    <= WRITE;
                                mem_wren_q <= 1'b1;
                                mem_data_q <= w_wdata;
                            end else begin
                                state_q <= READ;
                                cnt_q   <= CNT_INIT;
                            end
                        end
                    end
                end
                READ: begin
                    // mem_q is valid on the last READ edge, READ_LATENCY edges after acceptance.
                    if (cnt_q == 2'd0) begin
                        state_q       <= RESP;
                        load_data_q   <= w_rdata;
                        resp_valid_q  <= 1'b1;
                        err_q         <= 1'b0;
                        mem_byteena_q <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                WRITE: begin
                    state_q       <= RESP;
                    mem_wren_q    <= 1'b0;
                    mem_byteena_q <= 4'd0;
                    load_data_q   <= 32'd0;
                    resp_valid_q  <= 1'b1;
                    err_q         <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign err         = err_q;
    assign load_data   = load_data_q;
    assign mem_addr    = mem_addr_q;
    assign mem_byteena = mem_byteena_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit -- directed bench with a 16-word latency-2 memory model.
// Rev 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int AW = 16;
    localparam int RL = 2;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          is_store;
    logic [2:0]    funct3;
    logic [31:0]   base;
    logic [31:0]   offset;
    logic [31:0]   store_data;
    logic          resp_valid;
    logic [31:0]   load_data;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_byteena;
    logic [31:0]   mem_data;
    logic          mem_wren;
    logic [31:0]   mem_q;

    load_store_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .base(base), .offset(offset),
        .store_data(store_data), .resp_valid(resp_valid), .load_data(load_data),
        .err(err), .mem_addr(mem_addr), .mem_byteena(mem_byteena),
        .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: one registered read stage, so mem_q is valid RL=2 cycles after mem_addr.
    logic [31:0] mem [0:15];
    logic [31:0] pipe_q;
    assign mem_q = pipe_q;
    always @(posedge clk) begin
        pipe_q <= mem[mem_addr[3:0]];
        if (mem_wren) begin
            if (mem_byteena[0]) mem[mem_addr[3:0]][7:0]   <= mem_data[7:0];
            if (mem_byteena[1]) mem[mem_addr[3:0]][15:8]  <= mem_data[15:8];
            if (mem_byteena[2]) mem[mem_addr[3:0]][23:16] <= mem_data[23:16];
            if (mem_byteena[3]) mem[mem_addr[3:0]][31:24] <= mem_data[31:24];
        end
    end

    int errors = 0;
    int checks = 0;

    int          lat;
    logic [31:0] r_ld;
    logic        r_err;
    int          wr_cnt;
    logic [AW-1:0] wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [3:0]  be_or;
    logic        rdy_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd, input logic hold);
        is_store = st; funct3 = f3; base = b; offset = o; store_data = sd;
        req_valid = 1'b1;
        chk("accept_ready", 32'(req_ready), 32'd1);
        tick;
        req_valid = hold;
        if (!hold) begin
            base = $urandom; offset = $urandom; store_data = $urandom;
        end
    endtask

    // Cycle 1 is the first cycle after the acceptance edge; lat stays 0 on timeout.
    task automatic wait_resp;
        lat = 0; r_ld = 32'hDEADBEEF; r_err = 1'bx;
        wr_cnt = 0; wr_addr = '0; wr_be = 4'd0; wr_data = 32'd0;
        be_or = 4'd0; rdy_seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            be_or = be_or | mem_byteena;
            if (mem_wren) begin
                wr_cnt++; wr_addr = mem_addr; wr_be = mem_byteena; wr_data = mem_data;
            end
            if (resp_valid) begin
                lat = k; r_ld = load_data; r_err = err;
                return;
            end
            if (req_ready) rdy_seen = 1'b1;
            tick;
        end
    endtask

    task automatic after_resp(input logic [31:0] ld_exp);
        tick;
        chk("pulse_end", 32'(resp_valid), 32'd0);
        chk("ld_hold", load_data, ld_exp);
        chk("idle_be", 32'(mem_byteena), 32'd0);
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] b,
                             input logic [31:0] o, input logic [31:0] ld_exp);
        start(1'b0, f3, b, o, 32'd0, 1'b0);
        wait_resp;
        chk({tag, "_lat"}, 32'(lat), 32'(RL + 1));
        chk({tag, "_data"}, r_ld, ld_exp);
        chk({tag, "_err"}, 32'(r_err), 32'd0);
        chk({tag, "_nowren"}, 32'(wr_cnt), 32'd0);
        after_resp(ld_exp);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        base = 32'd0; offset = 32'd0; store_data = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[1] = 32'h13572468;
        mem[3] = 32'h8000F0A1;
        pipe_q = 32'd0;

        #2 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_be", 32'(mem_byteena), 32'd0);
        chk("rst_wdata", mem_data, 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        tick;

        load_case("lb",  3'b000, 32'd12, 32'd1, 32'hFFFFFFF0);
        load_case("lbu", 3'b100, 32'd12, 32'd1, 32'h000000F0);
        load_case("lh",  3'b001, 32'd14, 32'd0, 32'hFFFF8000);
        load_case("lhu", 3'b101, 32'd14, 32'd0, 32'h00008000);

        start(1'b1, 3'b000, 32'h10, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        wait_resp;
        chk("sb_lat", 32'(lat), 32'd2);
        chk("sb_wcnt", 32'(wr_cnt), 32'd1);
        chk("sb_addr", 32'(wr_addr), 32'd3);
        chk("sb_be", 32'(wr_be), 32'b1000);
        chk("sb_wdata", wr_data, 32'h78787878);
        chk("sb_err", 32'(r_err), 32'd0);
        chk("sb_ld", r_ld, 32'd0);
        after_resp(32'd0);
        chk("sb_wren_off", 32'(mem_wren), 32'd0);

        load_case("lbu_after_sb", 3'b100, 32'd15, 32'd0, 32'h00000078);

        start(1'b0, 3'b010, 32'd6, 32'd0, 32'd0, 1'b0);
        wait_resp;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_lat", 32'(lat), 32'd1);
        chk("lw_mis_err", 32'(r_err), 32'd1);
        chk("lw_mis_ld", r_ld, 32'd0);
        chk("lw_mis_be", 32'(be_or), 32'd0);
        chk("lw_mis_wren", 32'(wr_cnt), 32'd0);
        after_resp(32'd0);
`else
        chk("lw_al_lat", 32'(lat), 32'(RL + 1));
        chk("lw_al_err", 32'(r_err), 32'd0);
        chk("lw_al_ld", r_ld, 32'h13572468);
        after_resp(32'h13572468);
`endif

        start(1'b0, 3'b011, 32'd12, 32'd0, 32'd0, 1'b0);
        wait_resp;
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_err", 32'(r_err), 32'd1);
        chk("ill_ld", r_ld, 32'd0);
        chk("ill_be", 32'(be_or), 32'd0);
        after_resp(32'd0);

        // Held req_valid: inputs change after acceptance; the second request waits for IDLE.
        start(1'b0, 3'b100, 32'd13, 32'd0, 32'd0, 1'b1);
        funct3 = 3'b010; base = 32'd4; offset = 32'd0;
        wait_resp;
        chk("hold_lat", 32'(lat), 32'(RL + 1));
        chk("hold_ld", r_ld, 32'h000000F0);
        chk("hold_busy_rdy", 32'(rdy_seen), 32'd0);
        chk("hold_wren", 32'(wr_cnt), 32'd0);
        tick;
        chk("hold_idle_rdy", 32'(req_ready), 32'd1);
        chk("hold_idle_resp", 32'(resp_valid), 32'd0);
        tick;
        req_valid = 1'b0;
        wait_resp;
        chk("hold2_lat", 32'(lat), 32'(RL + 1));
        chk("hold2_ld", r_ld, 32'h13572468);
        after_resp(32'h13572468);

        // Reset pulsed mid-READ.
        start(1'b0, 3'b010, 32'd12, 32'd0, 32'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_resp", 32'(resp_valid), 32'd0);
        chk("mid_rst_be", 32'(mem_byteena), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_ld", load_data, 32'd0);
        chk("mid_rst_wdata", mem_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_cnt = 0; lat = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) lat++;
            if (mem_wren) wr_cnt++;
        end
        chk("abort_noresp", 32'(lat), 32'd0);
        chk("abort_nowren", 32'(wr_cnt), 32'd0);

        // First edge after reset release accepts: SH to upper half of word 0.
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        start(1'b1, 3'b001, 32'd0, 32'd2, 32'hAAAA5555, 1'b0);
        wait_resp;
        chk("sh_lat", 32'(lat), 32'd2);
        chk("sh_addr", 32'(wr_addr), 32'd0);
        chk("sh_be", 32'(wr_be), 32'b1100);
        chk("sh_wdata", wr_data, 32'h55555555);
        after_resp(32'd0);
        chk("sh_mem", mem[0], 32'h55550000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
